// File: rtl/semaforo_sensor_timer.sv
// Traffic-light front end: detector sync/debounce, sticky car
// requests, and the one-second / phase-step timebase.
module semaforo_sensor_timer #(
    parameter int PRESC     = 50000000,
    parameter int PHASE_SEC = 10,
    parameter int DEB_LEN   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       raw_sa,
    input  logic       raw_sb,
    input  logic       clr_a,
    input  logic       clr_b,
    input  logic       enable,
    input  logic       restart,
    output logic       sa,
    output logic       sb,
    output logic       sec_tick,
    output logic       step,
    output logic [7:0] remain
);

    localparam int PW = $clog2(PRESC);
    localparam int DW = $clog2(DEB_LEN + 1);

    localparam logic [PW-1:0] P_LAST = PW'(PRESC - 1);
    localparam logic [DW-1:0] D_LAST = DW'(DEB_LEN - 1);
    localparam logic [7:0]    S_LAST = 8'(PHASE_SEC - 1);
    localparam logic [7:0]    S_INIT = 8'(PHASE_SEC);

    logic [1:0]    raw;
    logic [1:0]    clr;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    deb;
    logic [1:0]    req;
    logic [DW-1:0] deb_cnt [2];

    logic [PW-1:0] presc_cnt;
    logic [7:0]    sec_cnt;
    logic          wrap;

    // bit 0 is street A, bit 1 is street B
    assign raw = {raw_sb, raw_sa};
    assign clr = {clr_b, clr_a};

    assign sa = req[0];
    assign sb = req[1];

    // restart wins over a coincident wrap, so the pulse is dropped
    assign wrap = enable && !restart && (presc_cnt == P_LAST);

    // two-flop synchroniser for the asynchronous detector loops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // accept a level change only after DEB_LEN mismatching cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb <= '0;
            for (int i = 0; i < 2; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == D_LAST) begin
                    deb[i]     <= ~deb[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // sticky request: a present car overrides the acknowledge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req <= '0;
        end else begin
            req <= deb | (req & ~clr);
        end
    end

    // prescaler counting clk cycles within one second
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_cnt <= '0;
        end else if (restart) begin
            presc_cnt <= '0;
        end else if (enable) begin
            if (presc_cnt == P_LAST) begin
                presc_cnt <= '0;
            end else begin
                presc_cnt <= presc_cnt + 1'b1;
            end
        end
    end

    // second counter, registered pulses and seconds remaining
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sec_cnt  <= '0;
            remain   <= S_INIT;
            sec_tick <= 1'b0;
            step     <= 1'b0;
        end else if (restart) begin
            sec_cnt  <= '0;
            remain   <= S_INIT;
            sec_tick <= 1'b0;
            step     <= 1'b0;
        end else begin
            sec_tick <= wrap;
            step     <= wrap && (sec_cnt == S_LAST);
            if (wrap) begin
                if (sec_cnt == S_LAST) begin
                    sec_cnt <= '0;
                    remain  <= S_INIT;
                end else begin
                    sec_cnt <= sec_cnt + 8'd1;
                    remain  <= S_INIT - sec_cnt - 8'd1;
                end
            end
        end
    end

endmodule
